// File: rtl/cfgsp_arbiter_pkg.sv
// Shared types and constants for the config-space port arbiter.
package cfgsp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [3:0] STRB_READ = 4'b0000;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_WD     = 32;
  localparam int DEF_ADDR_WD     = 16;
  localparam int DEF_TIMEOUT_CYC = 256;

  // Index width that stays at least one bit wide.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfgsp_arbiter_if.sv
// Bundle between the requesters, the arbiter and the config-space block.
// Handshake: a requester holds req_i and its lanes until it sees its one-cycle gnt_o; the
// arbiter then drives cs_valid_o until cs_ack_i and returns a one-cycle ack_o to the owner.
interface cfgsp_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 16
);
  import cfgsp_arb_pkg::*;

  localparam int PTR_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]         req_i;
  logic [NUM_REQ*ADDR_WD-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WD-1:0] req_data_i;
  logic [NUM_REQ*4-1:0]       req_strb_i;
  logic [NUM_REQ-1:0]         gnt_o;
  logic [NUM_REQ-1:0]         ack_o;
  logic [DATA_WD-1:0]         rdata_o;
  logic                       err_o;
  logic                       cs_valid_o;
  logic [ADDR_WD-1:0]         cs_addr_o;
  logic [DATA_WD-1:0]         cs_wdata_o;
  logic [3:0]                 cs_strb_o;
  logic                       cs_read_o;
  logic                       cs_ack_i;
  logic [DATA_WD-1:0]         cs_rdata_i;
  logic                       busy_o;
  arb_state_e                 dbg_state;
  logic [PTR_W-1:0]           dbg_rr_ptr;

  modport slave (
    input  req_i, req_addr_i, req_data_i, req_strb_i, cs_ack_i, cs_rdata_i,
    output gnt_o, ack_o, rdata_o, err_o, cs_valid_o, cs_addr_o, cs_wdata_o,
           cs_strb_o, cs_read_o, busy_o, dbg_state, dbg_rr_ptr
  );

  modport master (
    output req_i, req_addr_i, req_data_i, req_strb_i, cs_ack_i, cs_rdata_i,
    input  gnt_o, ack_o, rdata_o, err_o, cs_valid_o, cs_addr_o, cs_wdata_o,
           cs_strb_o, cs_read_o, busy_o, dbg_state, dbg_rr_ptr
  );

endinterface

// File: rtl/cfgsp_arbiter_rr_picker.sv
// Rotate-priority encoder: first set request at or above ptr, wrapping at NUM_REQ.
module rr_picker
  import cfgsp_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PTR_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               valid,
  output logic [PTR_W-1:0]   idx
);

  int               cand;
  logic [PTR_W-1:0] cand_idx;

  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/cfgsp_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters onto the single config-space port,
// one transaction at a time, with a timeout that completes with err_o.
module cfgsp_arbiter
  import cfgsp_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_WD     = DEF_DATA_WD,
  parameter int ADDR_WD     = DEF_ADDR_WD,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic            S_CLK,
  input logic            PRESETn_SYNC,
  cfgsp_arbiter_if.slave bus
);

  localparam int PTR_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic [DATA_WD-1:0] wdata_q, wdata_d;
  logic [3:0]         strb_q, strb_d;
  logic [DATA_WD-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;

  // Explicit compare so non-power-of-two NUM_REQ wraps correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req_i),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge S_CLK or negedge PRESETn_SYNC) begin
    if (!PRESETn_SYNC) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A withdrawn request forfeits its turn without reaching config space.
        if (bus.req_i[owner_q]) begin
          addr_d  = bus.req_addr_i[owner_q*ADDR_WD +: ADDR_WD];
          wdata_d = bus.req_data_i[owner_q*DATA_WD +: DATA_WD];
          strb_d  = bus.req_strb_i[owner_q*4 +: 4];
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end else begin
          rr_ptr_d = ptr_inc(owner_q);
          state_d  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
        if (bus.cs_ack_i) begin
          rdata_d = (strb_q == STRB_READ) ? bus.cs_rdata_i : '0;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d    = '0;
        rr_ptr_d = ptr_inc(owner_q);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // cs_read_o is qualified by valid so that it reads 0 outside a transaction.
  always_comb begin
    bus.gnt_o      = '0;
    bus.ack_o      = '0;
    bus.rdata_o    = '0;
    bus.err_o      = 1'b0;
    bus.cs_valid_o = 1'b0;
    bus.cs_read_o  = 1'b0;
    case (state_q)
      ST_GRANT: bus.gnt_o[owner_q] = 1'b1;
      ST_ISSUE: begin
        bus.cs_valid_o = 1'b1;
        bus.cs_read_o  = (strb_q == STRB_READ);
      end
      ST_RESP: begin
        bus.ack_o[owner_q] = 1'b1;
        bus.rdata_o        = rdata_q;
        bus.err_o          = err_q;
      end
      default: ;
    endcase
  end

  assign bus.cs_addr_o  = addr_q;
  assign bus.cs_wdata_o = wdata_q;
  assign bus.cs_strb_o  = strb_q;
  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.dbg_state  = state_q;
  assign bus.dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_cfgsp_arbiter.sv
// Scoreboard bench for cfgsp_arbiter: a queue-based round-robin model predicts grants and
// completions, a memory-backed config-space responder answers the issued transactions.
module tb_cfgsp_arbiter;
  import cfgsp_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic S_CLK;
  logic PRESETn_SYNC;

  initial S_CLK = 1'b0;
  always #5 S_CLK = ~S_CLK;

  cfgsp_arbiter_if #(.NUM_REQ(NR), .DATA_WD(DW), .ADDR_WD(AW)) bus ();

  cfgsp_arbiter #(.NUM_REQ(NR), .DATA_WD(DW), .ADDR_WD(AW), .TIMEOUT_CYC(TO)) dut (
    .S_CLK        (S_CLK),
    .PRESETn_SYNC (PRESETn_SYNC),
    .bus          (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
  } txn_t;

  typedef struct {
    int            owner;
    txn_t          t;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  int            exp_gnt_q[$];
  txn_t          work_q[NR][$];
  txn_t          model_work[NR][$];
  logic [DW-1:0] ref_mem[64];
  logic [DW-1:0] cs_mem[64];

  int checks = 0;
  int failures = 0;
  int model_ptr = 0;
  int forced_delay = -1;
  int forced_hold = -1;
  bit spurious_en = 1'b0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired, got no event expected one", name);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [3:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_dead(input logic [AW-1:0] a);
    return a[AW-1 -: 4] == 4'hF;
  endfunction

  task automatic add_txn(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] s);
    txn_t t;
    t.addr = a; t.data = d; t.strb = s;
    work_q[k].push_back(t);
    model_work[k].push_back(t);
  endtask

  // Reference: serve pending requesters in rotating order from model_ptr, one at a time.
  task automatic model_batch();
    int   o;
    int   c;
    exp_t e;
    bit   tmo;
    for (int n = 0; n < 64; n++) begin
      o = -1;
      for (int i = 0; i < NR; i++) begin
        c = (model_ptr + i) % NR;
        if (o < 0 && model_work[c].size() > 0) o = c;
      end
      if (o < 0) break;
      e.owner = o;
      e.t = model_work[o].pop_front();
      tmo = (forced_delay >= 0) ? (forced_delay > TO - 1) : is_dead(e.t.addr);
      if (tmo) begin
        e.rdata = '0; e.err = 1'b1;
      end else if (e.t.strb == 4'b0000) begin
        e.rdata = ref_mem[e.t.addr[7:2]]; e.err = 1'b0;
      end else begin
        ref_mem[e.t.addr[7:2]] = merge(ref_mem[e.t.addr[7:2]], e.t.data, e.t.strb);
        e.rdata = '0; e.err = 1'b0;
      end
      exp_q.push_back(e);
      exp_gnt_q.push_back(o);
      model_ptr = (o + 1) % NR;
    end
  endtask

  function automatic bit work_left();
    for (int k = 0; k < NR; k++) if (work_q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_lanes(input int k, input txn_t t);
    bus.req_addr_i[k*AW +: AW] = t.addr;
    bus.req_data_i[k*DW +: DW] = t.data;
    bus.req_strb_i[k*4 +: 4]   = t.strb;
  endtask

  // Requesters raise together, drop the cycle after their grant, re-raise on their ack.
  task automatic run_batch();
    bit   inflight[NR];
    bit   drop_next[NR];
    bit   active;
    int   budget;
    txn_t t;
    model_batch();
    for (int k = 0; k < NR; k++) begin inflight[k] = 1'b0; drop_next[k] = 1'b0; end
    budget = 0;
    active = 1'b1;
    while (active && budget < 2000) begin
      @(negedge S_CLK);
      budget++;
      for (int k = 0; k < NR; k++) begin
        if (drop_next[k]) begin bus.req_i[k] = 1'b0; drop_next[k] = 1'b0; end
        if (bus.gnt_o[k]) begin inflight[k] = 1'b1; drop_next[k] = 1'b1; end
        if (bus.ack_o[k]) inflight[k] = 1'b0;
        if (!bus.req_i[k] && !inflight[k] && !drop_next[k] && work_q[k].size() > 0) begin
          t = work_q[k].pop_front();
          drive_lanes(k, t);
          bus.req_i[k] = 1'b1;
        end
      end
      active = work_left() || (bus.req_i != '0);
      for (int k = 0; k < NR; k++) if (inflight[k]) active = 1'b1;
    end
    if (active) fail_now("batch_complete");
    repeat (6) @(negedge S_CLK);
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    logic [3:0] idx;
    bit dead;
    idx  = 4'($urandom_range(0, 15));
    dead = ($urandom_range(0, 15) == 0);
    t.addr = {(dead ? 4'hF : 4'h0), 4'h0, 2'b00, idx, 2'b00};
    t.data = $urandom;
    t.strb = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    return t;
  endfunction

  // Config-space responder backed by its own memory.
  initial begin
    int  ack_left;
    int  n;
    int  delay;
    bit  serving;
    bus.cs_ack_i   = 1'b0;
    bus.cs_rdata_i = '0;
    ack_left = 0; n = 0; delay = 0; serving = 1'b0;
    for (int i = 0; i < 64; i++) cs_mem[i] = '0;
    forever begin
      @(negedge S_CLK);
      if (!PRESETn_SYNC) begin
        bus.cs_ack_i = 1'b0; ack_left = 0; serving = 1'b0;
      end else begin
        if (!bus.cs_valid_o) serving = 1'b0;
        if (ack_left > 0) begin
          ack_left--;
          if (ack_left == 0) begin bus.cs_ack_i = 1'b0; bus.cs_rdata_i = $urandom; end
        end else if (bus.cs_valid_o) begin
          if (!serving) begin
            serving = 1'b1;
            n = 0;
            delay = (forced_delay >= 0) ? forced_delay :
                    (is_dead(bus.cs_addr_o) ? 1000000 : int'($urandom_range(0, 4)));
          end
          if (n == delay) begin
            bus.cs_ack_i = 1'b1;
            ack_left = (forced_hold >= 0) ? forced_hold : int'($urandom_range(1, 4));
            if (bus.cs_strb_o == 4'b0000) bus.cs_rdata_i = cs_mem[bus.cs_addr_o[7:2]];
            else begin
              cs_mem[bus.cs_addr_o[7:2]] = merge(cs_mem[bus.cs_addr_o[7:2]],
                                                 bus.cs_wdata_o, bus.cs_strb_o);
              bus.cs_rdata_i = $urandom;
            end
          end
          n++;
        end else if (spurious_en && $urandom_range(0, 7) == 0) begin
          bus.cs_ack_i = 1'b1; bus.cs_rdata_i = $urandom; ack_left = 1;
        end
      end
    end
  end

  // Monitor: grants, issued payload, completions.
  logic          prev_valid = 1'b0;
  int            rise_cyc = 0;
  int            first_ack = -1;
  always @(negedge S_CLK) begin
    exp_t          e;
    logic [NR-1:0] oh;
    cyc++;
    if (PRESETn_SYNC) begin
      if (bus.gnt_o != '0) begin
        if (exp_gnt_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_gnt: got gnt_o=%b expected none", bus.gnt_o);
        end else begin
          oh = '0; oh[exp_gnt_q.pop_front()] = 1'b1;
          check("gnt_owner", 64'(bus.gnt_o), 64'(oh));
        end
      end
      if (bus.cs_valid_o && !prev_valid) begin
        rise_cyc = cyc;
        first_ack = -1;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_issue: got cs_valid_o=1 expected 0");
        end else begin
          check("cs_addr", 64'(bus.cs_addr_o), 64'(exp_q[0].t.addr));
          check("cs_wdata", 64'(bus.cs_wdata_o), 64'(exp_q[0].t.data));
          check("cs_strb", 64'(bus.cs_strb_o), 64'(exp_q[0].t.strb));
          check("cs_read", 64'(bus.cs_read_o), 64'(exp_q[0].t.strb == 4'b0000));
        end
      end
      if (bus.cs_valid_o && bus.cs_ack_i && first_ack < 0) first_ack = cyc;
      if (bus.ack_o != '0) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_ack: got ack_o=%b expected none", bus.ack_o);
        end else begin
          e = exp_q.pop_front();
          oh = '0; oh[e.owner] = 1'b1;
          check("ack_owner", 64'(bus.ack_o), 64'(oh));
          check("rdata", 64'(bus.rdata_o), 64'(e.rdata));
          check("err", 64'(bus.err_o), 64'(e.err));
          check("valid_low_at_ack", 64'(bus.cs_valid_o), 64'(0));
          if (e.err) check("timeout_latency", 64'(cyc - rise_cyc), 64'(TO));
          else       check("ack_latency", 64'(cyc), 64'(first_ack + 1));
        end
      end else begin
        check("idle_rdata_err", 64'({bus.err_o, bus.rdata_o}), 64'(0));
      end
    end
    prev_valid = bus.cs_valid_o;
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, 64'({bus.gnt_o, bus.ack_o, bus.err_o, bus.cs_valid_o,
                                bus.cs_read_o, bus.busy_o}), 64'(0));
    check({tag, "_rdata"}, 64'(bus.rdata_o), 64'(0));
    check({tag, "_cs_addr"}, 64'(bus.cs_addr_o), 64'(0));
    check({tag, "_cs_wdata"}, 64'(bus.cs_wdata_o), 64'(0));
    check({tag, "_cs_strb"}, 64'(bus.cs_strb_o), 64'(0));
  endtask

  initial begin
    txn_t t;
    int   cnt;
    bit   any;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    bus.req_i = '0; bus.req_addr_i = '0; bus.req_data_i = '0; bus.req_strb_i = '0;
    PRESETn_SYNC = 1'b1;
    #1 PRESETn_SYNC = 1'b0;
    #1 check_outputs_zero("reset");
    check("reset_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    check("reset_rr_ptr", 64'(bus.dbg_rr_ptr), 64'(0));
    repeat (3) @(negedge S_CLK);
    PRESETn_SYNC = 1'b1;
    repeat (2) @(negedge S_CLK);

    // Round-robin with requester 0 coming back for a second turn: 0,1,3,0.
    add_txn(0, 16'h0010, 32'h1111_0000, 4'hF);
    add_txn(0, 16'h0014, 32'h2222_0000, 4'hF);
    add_txn(1, 16'h0018, 32'h3333_0000, 4'hF);
    add_txn(3, 16'h001C, 32'h4444_0000, 4'hF);
    run_batch();

    // Single write, ack three cycles into ISSUE.
    forced_delay = 3; forced_hold = 1;
    add_txn(0, 16'h0040, 32'hDEAD_BEEF, 4'hF);
    run_batch();

    // Write then read back through a different requester.
    forced_delay = -1; forced_hold = -1;
    add_txn(1, 16'h0080, 32'h1234_5678, 4'hF);
    add_txn(2, 16'h0080, 32'h0, 4'b0000);
    run_batch();

    // Timeouts: no ack ever for the F-page.
    add_txn(3, 16'hF100, 32'hAAAA_5555, 4'hF);
    add_txn(1, 16'hF104, 32'h0, 4'b0000);
    run_batch();

    // Ack on the last counted cycle wins over the timeout.
    forced_delay = TO - 1; forced_hold = 1;
    add_txn(1, 16'h0080, 32'h0, 4'b0000);
    run_batch();

    // One long-held ack produces one completion.
    forced_delay = 1; forced_hold = 5;
    add_txn(2, 16'h0044, 32'h0BAD_F00D, 4'h3);
    run_batch();

    // Reset mid-ISSUE aborts without an ack and returns to the initial pointer.
    forced_delay = -1; forced_hold = -1;
    add_txn(2, 16'hF010, 32'hCAFE_F00D, 4'hF);
    model_batch();
    t = work_q[2].pop_front();
    @(negedge S_CLK);
    drive_lanes(2, t);
    bus.req_i[2] = 1'b1;
    cnt = 0;
    while (!bus.gnt_o[2] && cnt < 20) begin @(negedge S_CLK); cnt++; end
    if (cnt >= 20) fail_now("reset_test_gnt");
    @(negedge S_CLK);
    bus.req_i[2] = 1'b0;
    cnt = 0;
    while (!bus.cs_valid_o && cnt < 20) begin @(negedge S_CLK); cnt++; end
    if (cnt >= 20) fail_now("reset_test_issue");
    repeat (3) @(negedge S_CLK);
    @(posedge S_CLK);
    #3 PRESETn_SYNC = 1'b0;
    #1 check_outputs_zero("mid_reset");
    exp_q.delete();
    exp_gnt_q.delete();
    model_ptr = 0;
    repeat (3) @(negedge S_CLK);
    PRESETn_SYNC = 1'b1;
    @(negedge S_CLK);
    check("post_reset_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    check("post_reset_rr_ptr", 64'(bus.dbg_rr_ptr), 64'(0));
    repeat (5) @(negedge S_CLK);

    // Randomized batches with stray acks outside ISSUE.
    spurious_en = 1'b1;
    for (int b = 0; b < 30; b++) begin
      any = 1'b0;
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          cnt = $urandom_range(1, 3);
          for (int j = 0; j < cnt; j++) begin
            t = rand_txn();
            add_txn(k, t.addr, t.data, t.strb);
          end
          any = 1'b1;
        end
      end
      if (!any) begin
        t = rand_txn();
        add_txn(int'($urandom_range(0, NR - 1)), t.addr, t.data, t.strb);
      end
      run_batch();
    end
    spurious_en = 1'b0;
    repeat (5) @(negedge S_CLK);
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("exp_gnt_q_drained", 64'(exp_gnt_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
